mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Fetch/LSU requester ports plus the single-outstanding memory bus of mem_bus_arbiter.
// master = arbiter side; slave = requesters and memory model side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_gnt;
  logic [DATA_WIDTH-1:0] f_rdata;
  logic                  f_rvalid;
  logic                  f_err;

  logic                  l_req;
  logic                  l_we;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic                  l_gnt;
  logic [DATA_WIDTH-1:0] l_rdata;
  logic                  l_rvalid;
  logic                  l_err;

  logic                  flush;

  logic                  mem_req_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wdata_oe;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_data_valid;
  logic                  busy;

  modport master (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, flush,
           mem_rdata, mem_data_valid,
    output f_gnt, f_rdata, f_rvalid, f_err,
           l_gnt, l_rdata, l_rvalid, l_err,
           mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wdata_oe, busy
  );

  modport slave (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, flush,
           mem_rdata, mem_data_valid,
    input  f_gnt, f_rdata, f_rvalid, f_err,
           l_gnt, l_rdata, l_rvalid, l_err,
           mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wdata_oe, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin fetch/LSU arbiter onto a single-outstanding memory bus; grant 1 cycle after request,
// rvalid/err 1 cycle after completion/timeout; requests simply wait (ignored) while busy.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_BUSY    = 1'b1;
  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_LSU   = 1'b1;
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  logic [0:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  f_gnt_q, f_gnt_d, l_gnt_q, l_gnt_d;
  logic                  f_rvalid_q, f_rvalid_d, l_rvalid_q, l_rvalid_d;
  logic                  f_err_q, f_err_d, l_err_q, l_err_d;
  logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d, l_rdata_q, l_rdata_d;

  logic f_elig, l_elig, pick_fetch;

  assign f_elig     = bus.f_req & ~bus.flush;
  assign l_elig     = bus.l_req;
  assign pick_fetch = f_elig & (~l_elig | (last_q == OWN_LSU));

  always_comb begin
    logic drop_now;
    drop_now   = drop_q;
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    f_rdata_d  = f_rdata_q;
    l_rdata_d  = l_rdata_q;
    f_gnt_d    = 1'b0;
    l_gnt_d    = 1'b0;
    f_rvalid_d = 1'b0;
    l_rvalid_d = 1'b0;
    f_err_d    = 1'b0;
    l_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (f_elig | l_elig) begin
          state_d = S_BUSY;
          cnt_d   = 8'd0;
          drop_d  = 1'b0;
          if (pick_fetch) begin
            owner_d = OWN_FETCH;
            last_d  = OWN_FETCH;
            addr_d  = bus.f_addr;
            we_d    = 1'b0;
            f_gnt_d = 1'b1;
          end else begin
            owner_d = OWN_LSU;
            last_d  = OWN_LSU;
            addr_d  = bus.l_addr;
            we_d    = bus.l_we;
            wdata_d = bus.l_wdata;
            l_gnt_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // A flush in the final cycle still suppresses that fetch's response.
        drop_now = drop_q | ((owner_q == OWN_FETCH) & bus.flush);
        drop_d   = drop_now;
        if (bus.mem_data_valid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_FETCH) begin
            if (!drop_now) begin
              f_rvalid_d = 1'b1;
              f_rdata_d  = bus.mem_rdata;
            end
          end else begin
            l_rvalid_d = 1'b1;
            if (!we_q) l_rdata_d = bus.mem_rdata;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_FETCH) f_err_d = ~drop_now;
          else                      l_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_LSU;
      last_q     <= OWN_LSU;
      cnt_q      <= 8'd0;
      drop_q     <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      f_gnt_q    <= 1'b0;
      l_gnt_q    <= 1'b0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      l_err_q    <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      f_gnt_q    <= f_gnt_d;
      l_gnt_q    <= l_gnt_d;
      f_rvalid_q <= f_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      f_err_q    <= f_err_d;
      l_err_q    <= l_err_d;
      f_rdata_q  <= f_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign bus.busy          = (state_q == S_BUSY);
  assign bus.mem_req_valid = (state_q == S_BUSY);
  assign bus.mem_we        = (state_q == S_BUSY) & we_q;
  assign bus.mem_wdata_oe  = (state_q == S_BUSY) & we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.f_gnt         = f_gnt_q;
  assign bus.l_gnt         = l_gnt_q;
  assign bus.f_rvalid      = f_rvalid_q;
  assign bus.l_rvalid      = l_rvalid_q;
  assign bus.f_err         = f_err_q;
  assign bus.l_err         = l_err_q;
  assign bus.f_rdata       = f_rdata_q;
  assign bus.l_rdata       = l_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected grant/response events with their
// cycle stamps and per-cycle bus expectations; an independent monitor compares every cycle.
module tb_mem_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  ev_t gq[$];
  ev_t rq[$];

  // Reference state: what the bus and read-data outputs should show in the current cycle.
  bit           exp_busy    = 1'b0;
  bit           exp_we      = 1'b0;
  logic [AW-1:0] exp_addr   = '0;
  logic [DW-1:0] exp_wdata  = '0;
  logic [DW-1:0] exp_f_rdata = '0;
  logic [DW-1:0] exp_l_rdata = '0;
  bit           last_lsu    = 1'b1;

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    ev_t        e;
    logic [3:0] exp_code;
    forever begin
      @(negedge clk);
      #1;
      chk("busy", bus.busy, exp_busy);
      chk("mem_req_valid", bus.mem_req_valid, exp_busy);
      chk("mem_wdata_oe", bus.mem_wdata_oe, exp_busy && exp_we);
      if (exp_busy) begin
        chk("mem_addr", bus.mem_addr, exp_addr);
        chk("mem_we", bus.mem_we, exp_we);
        if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      end
      chk("f_rdata", bus.f_rdata, exp_f_rdata);
      chk("l_rdata", bus.l_rdata, exp_l_rdata);
      exp_code = 4'b0000;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        e = gq.pop_front();
        exp_code = e.code;
      end
      chk("grant{f,l}", {2'b00, bus.f_gnt, bus.l_gnt}, exp_code);
      exp_code = 4'b0000;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        e = rq.pop_front();
        exp_code = e.code;
      end
      chk("resp{frv,ferr,lrv,lerr}", {bus.f_rvalid, bus.f_err, bus.l_rvalid, bus.l_err}, exp_code);
    end
  end

  // One arbitration attempt starting in an IDLE cycle; returns at the negedge of the next IDLE cycle.
  // lat: BUSY cycle carrying mem_data_valid (>TMO means never), fc: BUSY cycle with flush,
  // rst_at: BUSY cycle in which reset is asserted (0 = none).
  task automatic round(input bit fr, input bit lr, input bit fl,
                       input logic [AW-1:0] fa, input logic [AW-1:0] la,
                       input bit we, input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                       input int lat, input int fc, input int rst_at);
    bit  wf, drop, done;
    int  last_b;
    ev_t e;
    bus.f_req = fr; bus.f_addr = fa;
    bus.l_req = lr; bus.l_addr = la; bus.l_we = we; bus.l_wdata = wd;
    bus.flush = fl; bus.mem_data_valid = 1'b0;
    exp_busy = 1'b0;
    if (!(fr && !fl) && !lr) begin
      @(negedge clk);
      bus.f_req = 1'b0; bus.l_req = 1'b0; bus.flush = 1'b0;
      return;
    end
    wf = (fr && !fl) && (!lr || last_lsu);
    last_lsu = !wf;
    e.code = wf ? 4'b0010 : 4'b0001;
    e.cyc  = cyc + 1;
    gq.push_back(e);
    drop   = 1'b0;
    done   = (lat <= TMO);
    last_b = done ? lat : TMO;
    for (int b = 1; b <= last_b; b++) begin
      @(negedge clk);
      bus.f_req = 1'b0; bus.l_req = 1'b0;
      if (b == rst_at) begin
        reset = 1'b0;
        bus.flush = 1'b0; bus.mem_data_valid = 1'b0;
        exp_busy = 1'b0; exp_f_rdata = '0; exp_l_rdata = '0; last_lsu = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        return;
      end
      exp_busy = 1'b1;
      exp_addr = wf ? fa : la;
      exp_we   = !wf && we;
      if (!wf && we) exp_wdata = wd;
      bus.flush = (b == fc);
      if (b == fc && wf) drop = 1'b1;
      bus.mem_data_valid = (b == lat);
      bus.mem_rdata = (b == lat) ? rd : $urandom();
    end
    if (!(wf && drop)) begin
      e.code = wf ? (done ? 4'b1000 : 4'b0100) : (done ? 4'b0010 : 4'b0001);
      e.cyc  = cyc + 1;
      rq.push_back(e);
    end
    @(negedge clk);
    bus.mem_data_valid = 1'b0; bus.flush = 1'b0;
    exp_busy = 1'b0;
    if (done && wf && !drop) exp_f_rdata = rd;
    if (done && !wf && !we)  exp_l_rdata = rd;
  endtask

  // IDLE cycles with stray flush/mem_data_valid that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      bus.f_req = 1'b0; bus.l_req = 1'b0;
      bus.flush = 1'($urandom_range(0, 1));
      bus.mem_data_valid = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom();
      exp_busy = 1'b0;
      @(negedge clk);
    end
    bus.flush = 1'b0; bus.mem_data_valid = 1'b0;
  endtask

  initial begin : stim
    bit fr, lr, fl, we;
    int lat, fc;
    bus.f_req = 1'b0; bus.f_addr = '0; bus.l_req = 1'b0; bus.l_we = 1'b0;
    bus.l_addr = '0; bus.l_wdata = '0; bus.flush = 1'b0;
    bus.mem_rdata = '0; bus.mem_data_valid = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_f_rvalid", bus.f_rvalid, 0);
    chk("rst_l_rvalid", bus.l_rvalid, 0);
    chk("rst_errs", {bus.f_err, bus.l_err}, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);

    // Contention: fetch, then LSU, then fetch again.
    round(1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 1'b0, 32'h0, 32'h1111_0001, 2, 0, 0);
    round(1'b1, 1'b1, 1'b0, 32'h104, 32'h204, 1'b0, 32'h0, 32'h2222_0002, 2, 0, 0);
    round(1'b1, 1'b1, 1'b0, 32'h108, 32'h208, 1'b0, 32'h0, 32'h3333_0003, 2, 0, 0);
    // Single fetch, data three cycles after mem_req_valid.
    round(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 3, 0, 0);
    // LSU write: l_rdata must keep the previous read value.
    round(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 1'b1, 32'h55AA, 32'hBAD0_BAD0, 2, 0, 0);
    // Timeout, then completion exactly on the timeout cycle.
    round(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, 32'h0, 99, 0, 0);
    round(1'b1, 1'b0, 1'b0, 32'h34, 32'h0, 1'b0, 32'h0, 32'hCAFE_0004, TMO, 0, 0);
    // Flush in BUSY cycle 2 drops the fetch response; the next fetch is served.
    round(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0BAD_F00D, 3, 2, 0);
    round(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 1, 0, 0);
    // Flush in IDLE blocks fetch but not LSU; flush has no effect on an LSU transaction.
    round(1'b1, 1'b1, 1'b1, 32'h48, 32'h4C, 1'b0, 32'h0, 32'h9999_0009, 2, 1, 0);
    // Reset mid-BUSY, then a tie goes to fetch again.
    round(1'b0, 1'b1, 1'b0, 32'h0, 32'h50, 1'b0, 32'h0, 32'h7777_0007, 3, 0, 2);
    round(1'b1, 1'b1, 1'b0, 32'h60, 32'h64, 1'b0, 32'h0, 32'h8888_0008, 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      fr  = 1'($urandom_range(0, 1));
      lr  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 4) == 0);
      we  = 1'($urandom_range(0, 1));
      lat = int'($urandom_range(1, TMO + 2));
      fc  = int'($urandom_range(0, TMO + 1));
      round(fr, lr, fl, $urandom(), $urandom(), we, $urandom(), $urandom(), lat, fc, 0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    chk("grant_queue_drained", gq.size(), 0);
    chk("resp_queue_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
